if_id_register: RTL and testbench
=================================

Name: if_id_register

Overview:
- Pipeline register between instruction fetch and decode.
- Latches the fetched instruction and PC+4, and splits the instruction into fields.
- Drives the 16-bit immediate and a registered zero/sign-extension select to the extension units in decode.
- Supports stall (hold), flush (bubble insertion) and a valid bit, so decode never acts on stale or squashed instructions.

Parameters:
- DATA_W, 32, width of instruction and PC.
- NOP_WORD, 32'h0000_0000, instruction word inserted on flush or reset (sll $0,$0,0).
- CNT_W, 16, width of optional event counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hold all stage registers this cycle.
- flush  input  1  replace stage contents with bubble.
- if_valid  input  1  fetch presents a valid instruction.
- if_instr  input  DATA_W  fetched instruction.
- if_pc4  input  DATA_W  PC+4 of fetched instruction.
- id_valid  output  1  decode-stage instruction is valid.
- id_instr  output  DATA_W  registered instruction.
- id_pc4  output  DATA_W  registered PC+4.
- id_opcode  output  6  instr[31:26].
- id_rs  output  5  instr[25:21].
- id_rt  output  5  instr[20:16].
- id_rd  output  5  instr[15:11].
- id_funct  output  6  instr[5:0].
- id_immediate  output  16  instr[15:0], to extension units.
- id_zero_ext  output  1  1 when opcode is ANDI (0x0C), ORI (0x0D) or XORI (0x0E); 0 otherwise.
- stall_cnt  output  CNT_W  stall events (feature only).
- flush_cnt  output  CNT_W  flush events (feature only).

Behaviour:
- All outputs are registered; latency is one clock from the IF inputs to the ID outputs.
- Field outputs are pure slices of the registered id_instr.
- id_zero_ext is decoded from if_instr and registered alongside id_instr, so it never lags the instruction it describes.
- Reset (synchronous, active-high, highest priority):
  - id_valid=0, id_instr=NOP_WORD, id_pc4=0, id_zero_ext=0, counters=0.
  - Fields are therefore 0.
- Priority per cycle: reset > flush > stall > load.
- Flush: id_instr=NOP_WORD, id_valid=0, id_zero_ext=0; id_pc4 is held.
- Flush while stall is asserted: flush wins; the bubble is inserted.
- Stall (no flush): every register holds, including id_valid.
- Load (no stall, no flush):
  - id_instr<=if_instr, id_pc4<=if_pc4, id_valid<=if_valid.
  - If if_valid=0, id_instr<=NOP_WORD and id_zero_ext<=0.
- Two-state view of the stage:
  - EMPTY (id_valid=0) -> FULL on a load with if_valid=1.
  - FULL -> EMPTY on flush, or on a load with if_valid=0.
  - FULL -> FULL on stall, or on a load with if_valid=1.
- Reset asserted mid-stall clears the stage regardless of stall.
- Any X on if_instr while if_valid=0 must not propagate; NOP_WORD is substituted.

Optional Feature:
- Macro: IF_ID_PERF_CNT_EN.
- Defined:
  - stall_cnt increments each cycle with stall=1 and flush=0 and reset=0.
  - flush_cnt increments each cycle with flush=1 and reset=0.
  - Both saturate at all-ones (no wrap) and clear on reset.
- Undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops are built.

Decomposition:
- Shared package (processor-wide): opcode constants OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_XORI=6'h0E, OP_RTYPE=6'h00; NOP_WORD constant; field bit-position constants.
- One sub-module: sat_event_counter (CNT_W, clk, reset, inc, count), instantiated twice under IF_ID_PERF_CNT_EN.

Test Plan:
- Reset then load if_valid=1, if_instr=32'h3421_ABCD (ORI), if_pc4=32'h0000_0004 -> next cycle: id_valid=1, id_opcode=0x0D, id_rs=1, id_rt=1, id_immediate=16'hABCD, id_zero_ext=1, id_pc4=4.
- Load ADDI 32'h2002_FFFF, then assert stall for 3 cycles while if_instr changes to 32'h0000_0000 -> outputs hold: id_immediate=16'hFFFF, id_zero_ext=0 throughout.
- FULL stage with stall=1 and flush=1 in the same cycle -> next cycle: id_valid=0, id_instr=0, id_zero_ext=0; flush_cnt=1 and stall_cnt unchanged (feature on).
- Load with if_valid=0 and if_instr=32'hFFFF_FFFF -> id_valid=0, id_instr=0, id_zero_ext=0.
- Assert reset during a multi-cycle stall holding ANDI 32'h3042_00FF -> next cycle: all outputs at reset values.
- Feature on with CNT_W=4: hold stall for 20 cycles -> stall_cnt saturates at 4'hF and stays there; reset returns it to 0.

Source files
------------

// File: rtl/if_id_register_pkg.sv
// -----------------------------------------------------------------------------
// if_id_register_pkg
// Processor-wide constants shared by the IF/ID pipeline register:
//   - opcode constants for the zero-extending immediate ops and R-type
//   - the NOP instruction word (sll $0,$0,0) used as a bubble
//   - MIPS field bit positions
//   - two-state stage type (EMPTY/FULL) and the zero-extension decode helper
// No ports (package).
// -----------------------------------------------------------------------------
package if_id_register_pkg;

  localparam logic [5:0]  OP_RTYPE = 6'h00;
  localparam logic [5:0]  OP_ANDI  = 6'h0C;
  localparam logic [5:0]  OP_ORI   = 6'h0D;
  localparam logic [5:0]  OP_XORI  = 6'h0E;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  localparam int OPC_MSB   = 31;
  localparam int OPC_LSB   = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;
  localparam int IMM_MSB   = 15;
  localparam int IMM_LSB   = 0;

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } stage_state_e;

  // Logical immediates are zero-extended; everything else sign-extends.
  function automatic logic is_zero_ext_op(input logic [5:0] opcode);
    logic result;
    case (opcode)
      OP_ANDI, OP_ORI, OP_XORI: result = 1'b1;
      default:                  result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/if_id_register_if.sv
// -----------------------------------------------------------------------------
// if_id_register_if
// Bundle between fetch/hazard control and the IF/ID register.
//   master : drives stall, flush, if_valid, if_instr, if_pc4; observes id_*
//            and the event counters.
//   slave  : the IF/ID register itself (inverse directions).
// Parameters: DATA_W (instruction/PC width), CNT_W (event counter width).
// -----------------------------------------------------------------------------
interface if_id_register_if #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
);

  logic              stall;
  logic              flush;
  logic              if_valid;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_pc4;

  logic              id_valid;
  logic [DATA_W-1:0] id_instr;
  logic [DATA_W-1:0] id_pc4;
  logic [5:0]        id_opcode;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [4:0]        id_rd;
  logic [5:0]        id_funct;
  logic [15:0]       id_immediate;
  logic              id_zero_ext;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport master (
    output stall, flush, if_valid, if_instr, if_pc4,
    input  id_valid, id_instr, id_pc4, id_opcode, id_rs, id_rt, id_rd,
           id_funct, id_immediate, id_zero_ext, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, flush, if_valid, if_instr, if_pc4,
    output id_valid, id_instr, id_pc4, id_opcode, id_rs, id_rt, id_rd,
           id_funct, id_immediate, id_zero_ext, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/if_id_register_sat_event_counter.sv
// -----------------------------------------------------------------------------
// sat_event_counter
// Saturating up-counter: increments on inc, sticks at all-ones, clears on
// synchronous active-high reset.
//   clk   : rising-edge clock
//   reset : synchronous clear (highest priority)
//   inc   : count this cycle
//   count : current value (CNT_W bits)
// -----------------------------------------------------------------------------
module sat_event_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Counter register with saturation at all-ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= {CNT_W{1'b0}};
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/if_id_register.sv
// -----------------------------------------------------------------------------
// if_id_register
// IF/ID pipeline register. Latches the fetched instruction and PC+4, exposes
// instruction fields as slices of the registered word, and registers the
// zero/sign-extension select alongside the instruction.
// Per-cycle priority: reset > flush > stall > load.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : if_id_register_if.slave (stall, flush, if_* in; id_*, counters out)
// Optional build macro IF_ID_PERF_CNT_EN adds saturating stall/flush event
// counters; without it stall_cnt/flush_cnt are constant 0.
// -----------------------------------------------------------------------------
module if_id_register #(
  parameter int                DATA_W   = 32,
  parameter logic [DATA_W-1:0] NOP_WORD = if_id_register_pkg::NOP_WORD,
  parameter int                CNT_W    = 16
) (
  input  logic           clk,
  input  logic           reset,
  if_id_register_if.slave bus
);

  import if_id_register_pkg::*;

  stage_state_e      state_r;
  stage_state_e      state_nxt;
  logic [DATA_W-1:0] instr_r;
  logic [DATA_W-1:0] instr_nxt;
  logic [DATA_W-1:0] pc4_r;
  logic [DATA_W-1:0] pc4_nxt;
  logic              zext_r;
  logic              zext_nxt;

  // Stage occupancy register (the valid bit).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_EMPTY;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Occupancy next-state: flush empties, stall holds, load follows if_valid.
  always_comb begin
    state_nxt = state_r;
    if (bus.flush) begin
      state_nxt = ST_EMPTY;
    end else if (bus.stall) begin
      state_nxt = state_r;
    end else if (bus.if_valid) begin
      state_nxt = ST_FULL;
    end else begin
      state_nxt = ST_EMPTY;
    end
  end

  // Datapath next values; an invalid fetch never reaches decode, so a
  // possibly-X if_instr is replaced by the bubble word.
  always_comb begin
    instr_nxt = instr_r;
    pc4_nxt   = pc4_r;
    zext_nxt  = zext_r;
    if (bus.flush) begin
      instr_nxt = NOP_WORD;
      zext_nxt  = 1'b0;
    end else if (bus.stall) begin
      instr_nxt = instr_r;
      pc4_nxt   = pc4_r;
      zext_nxt  = zext_r;
    end else begin
      pc4_nxt = bus.if_pc4;
      if (bus.if_valid) begin
        instr_nxt = bus.if_instr;
        zext_nxt  = is_zero_ext_op(bus.if_instr[OPC_MSB:OPC_LSB]);
      end else begin
        instr_nxt = NOP_WORD;
        zext_nxt  = 1'b0;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      instr_r <= NOP_WORD;
      pc4_r   <= {DATA_W{1'b0}};
      zext_r  <= 1'b0;
    end else begin
      instr_r <= instr_nxt;
      pc4_r   <= pc4_nxt;
      zext_r  <= zext_nxt;
    end
  end

  // Outputs: registered values and pure slices of the registered word.
  always_comb begin
    bus.id_valid     = (state_r == ST_FULL);
    bus.id_instr     = instr_r;
    bus.id_pc4       = pc4_r;
    bus.id_zero_ext  = zext_r;
    bus.id_opcode    = instr_r[OPC_MSB:OPC_LSB];
    bus.id_rs        = instr_r[RS_MSB:RS_LSB];
    bus.id_rt        = instr_r[RT_MSB:RT_LSB];
    bus.id_rd        = instr_r[RD_MSB:RD_LSB];
    bus.id_funct     = instr_r[FUNCT_MSB:FUNCT_LSB];
    bus.id_immediate = instr_r[IMM_MSB:IMM_LSB];
  end

`ifdef IF_ID_PERF_CNT_EN
  logic stall_evt;
  logic flush_evt;

  // A stall overridden by flush is not a stall event.
  assign stall_evt = bus.stall & ~bus.flush;
  assign flush_evt = bus.flush;

  sat_event_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_evt),
    .count (bus.stall_cnt)
  );

  sat_event_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_evt),
    .count (bus.flush_cnt)
  );
`else
  assign bus.stall_cnt = {CNT_W{1'b0}};
  assign bus.flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_if_id_register.sv
// -----------------------------------------------------------------------------
// tb_if_id_register
// Directed testbench for if_id_register with hand-computed expectations.
// Counter expectations follow IF_ID_PERF_CNT_EN (zero when undefined).
// -----------------------------------------------------------------------------
module tb_if_id_register;

`ifdef IF_ID_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  if_id_register_if #(.DATA_W(32), .CNT_W(4)) bus ();

  if_id_register #(.DATA_W(32), .NOP_WORD(32'h0000_0000), .CNT_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " valid"},    {31'd0, bus.id_valid},    32'h0);
    check_eq({tag, " instr"},    bus.id_instr,             32'h0);
    check_eq({tag, " pc4"},      bus.id_pc4,               32'h0);
    check_eq({tag, " zext"},     {31'd0, bus.id_zero_ext}, 32'h0);
    check_eq({tag, " opcode"},   {26'd0, bus.id_opcode},   32'h0);
    check_eq({tag, " imm"},      {16'd0, bus.id_immediate},32'h0);
    check_eq({tag, " stallcnt"}, {28'd0, bus.stall_cnt},   32'h0);
    check_eq({tag, " flushcnt"}, {28'd0, bus.flush_cnt},   32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset        = 1'b1;
    bus.stall    = 1'b0;
    bus.flush    = 1'b0;
    bus.if_valid = 1'b0;
    bus.if_instr = 32'h0000_0000;
    bus.if_pc4   = 32'h0000_0000;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;

    // ORI load
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h3421_ABCD;
    bus.if_pc4   = 32'h0000_0004;
    tick();
    check_eq("ori valid",  {31'd0, bus.id_valid},     32'h1);
    check_eq("ori opcode", {26'd0, bus.id_opcode},    32'h0D);
    check_eq("ori rs",     {27'd0, bus.id_rs},        32'h1);
    check_eq("ori rt",     {27'd0, bus.id_rt},        32'h1);
    check_eq("ori rd",     {27'd0, bus.id_rd},        32'h15);
    check_eq("ori funct",  {26'd0, bus.id_funct},     32'h0D);
    check_eq("ori imm",    {16'd0, bus.id_immediate}, 32'hABCD);
    check_eq("ori zext",   {31'd0, bus.id_zero_ext},  32'h1);
    check_eq("ori pc4",    bus.id_pc4,                32'h4);

    // ADDI load, then stall for 3 cycles while fetch changes
    bus.if_instr = 32'h2002_FFFF;
    bus.if_pc4   = 32'h0000_0008;
    tick();
    check_eq("addi opcode", {26'd0, bus.id_opcode},   32'h08);
    check_eq("addi zext",   {31'd0, bus.id_zero_ext}, 32'h0);
    bus.stall    = 1'b1;
    bus.if_instr = 32'h0000_0000;
    bus.if_pc4   = 32'h0000_000C;
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_eq("stall imm",      {16'd0, bus.id_immediate}, 32'hFFFF);
      check_eq("stall zext",     {31'd0, bus.id_zero_ext},  32'h0);
      check_eq("stall valid",    {31'd0, bus.id_valid},     32'h1);
      check_eq("stall instr",    bus.id_instr,              32'h2002_FFFF);
      check_eq("stall pc4",      bus.id_pc4,                32'h8);
      check_eq("stall stallcnt", {28'd0, bus.stall_cnt},    PERF ? i : 0);
    end

    // Flush during stall: bubble wins, pc4 held
    bus.flush = 1'b1;
    tick();
    check_eq("flush valid",    {31'd0, bus.id_valid},    32'h0);
    check_eq("flush instr",    bus.id_instr,             32'h0);
    check_eq("flush zext",     {31'd0, bus.id_zero_ext}, 32'h0);
    check_eq("flush pc4",      bus.id_pc4,               32'h8);
    check_eq("flush flushcnt", {28'd0, bus.flush_cnt},   PERF ? 32'h1 : 32'h0);
    check_eq("flush stallcnt", {28'd0, bus.stall_cnt},   PERF ? 32'h3 : 32'h0);
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Invalid fetch with all-ones word
    bus.if_valid = 1'b0;
    bus.if_instr = 32'hFFFF_FFFF;
    bus.if_pc4   = 32'h0000_0010;
    tick();
    check_eq("inv valid", {31'd0, bus.id_valid},    32'h0);
    check_eq("inv instr", bus.id_instr,             32'h0);
    check_eq("inv zext",  {31'd0, bus.id_zero_ext}, 32'h0);
    check_eq("inv pc4",   bus.id_pc4,               32'h10);

    // Invalid fetch with unknown word
    bus.if_instr = 32'hxxxx_xxxx;
    tick();
    check_eq("invx instr", bus.id_instr, 32'h0);

    // ANDI load, stall, then reset mid-stall
    bus.if_valid = 1'b1;
    bus.if_instr = 32'h3042_00FF;
    bus.if_pc4   = 32'h0000_0014;
    tick();
    check_eq("andi zext", {31'd0, bus.id_zero_ext},  32'h1);
    check_eq("andi imm",  {16'd0, bus.id_immediate}, 32'h00FF);
    bus.stall = 1'b1;
    tick();
    tick();
    check_eq("andi hold instr", bus.id_instr,          32'h3042_00FF);
    check_eq("andi stallcnt",   {28'd0, bus.stall_cnt}, PERF ? 32'h5 : 32'h0);
    reset = 1'b1;
    tick();
    check_reset_state("midstall reset");
    reset = 1'b0;

    // Saturation: 20 stall cycles
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) check_eq("sat cnt14", {28'd0, bus.stall_cnt}, PERF ? 32'hE : 32'h0);
      if (i == 15) check_eq("sat cnt15", {28'd0, bus.stall_cnt}, PERF ? 32'hF : 32'h0);
    end
    check_eq("sat cnt20",   {28'd0, bus.stall_cnt}, PERF ? 32'hF : 32'h0);
    check_eq("sat valid",   {31'd0, bus.id_valid},  32'h0);
    reset = 1'b1;
    tick();
    check_eq("sat cleared", {28'd0, bus.stall_cnt}, 32'h0);
    reset     = 1'b0;
    bus.stall = 1'b0;

    // Release: fresh load after reset
    bus.if_instr = 32'h3842_1234;
    bus.if_pc4   = 32'h0000_0018;
    tick();
    check_eq("xori opcode", {26'd0, bus.id_opcode},   32'h0E);
    check_eq("xori zext",   {31'd0, bus.id_zero_ext}, 32'h1);
    check_eq("xori pc4",    bus.id_pc4,               32'h18);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
